// File: rtl/udp_rx_port_filter.sv
// rtl/udp_rx_port_filter.sv - UDP receive filter: forwards datagrams for LOCAL_PORT, drops the rest
module udp_rx_port_filter #(
    parameter logic [15:0] LOCAL_PORT = 16'd1234,
    parameter logic [15:0] MIN_LENGTH = 16'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_hdr_valid,
    output logic        s_hdr_ready,
    input  logic [31:0] s_hdr_ip_source_ip,
    input  logic [15:0] s_hdr_source_port,
    input  logic [15:0] s_hdr_dest_port,
    input  logic [15:0] s_hdr_length,
    output logic        m_hdr_valid,
    input  logic        m_hdr_ready,
    output logic [31:0] m_hdr_ip_source_ip,
    output logic [15:0] m_hdr_source_port,
    output logic [15:0] m_hdr_length,
    input  logic [7:0]  s_payload_tdata,
    input  logic        s_payload_tvalid,
    output logic        s_payload_tready,
    input  logic        s_payload_tlast,
    output logic [7:0]  m_payload_tdata,
    output logic        m_payload_tvalid,
    input  logic        m_payload_tready,
    output logic        m_payload_tlast,
    output logic [15:0] drop_count
);

    typedef enum logic [1:0] {IDLE, HDR_OUT, PASS, DROP} state_t;

    state_t state;
    logic   hdr_fire;
    logic   hdr_match;
    logic   in_pass;
    logic   in_drop;
    logic   beat_fire;

    // Gating with rst keeps a handshake from slipping through in the reset cycle.
    assign in_pass = (state == PASS) && !rst;
    assign in_drop = (state == DROP) && !rst;

    assign s_hdr_ready = (state == IDLE) && !rst;
    assign hdr_fire    = s_hdr_valid && s_hdr_ready;
    assign hdr_match   = (s_hdr_dest_port == LOCAL_PORT) && (s_hdr_length >= MIN_LENGTH);

    assign m_payload_tdata  = s_payload_tdata;
    assign m_payload_tlast  = s_payload_tlast;
    assign m_payload_tvalid = in_pass && s_payload_tvalid;
    assign s_payload_tready = in_pass ? m_payload_tready : in_drop;
    assign beat_fire        = s_payload_tvalid && s_payload_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            m_hdr_valid        <= 1'b0;
            m_hdr_ip_source_ip <= 32'd0;
            m_hdr_source_port  <= 16'd0;
            m_hdr_length       <= 16'd0;
            drop_count         <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hdr_fire) begin
                        m_hdr_ip_source_ip <= s_hdr_ip_source_ip;
                        m_hdr_source_port  <= s_hdr_source_port;
                        m_hdr_length       <= s_hdr_length;
                        if (hdr_match) begin
                            state       <= HDR_OUT;
                            m_hdr_valid <= 1'b1;
                        end else begin
                            state      <= DROP;
                            drop_count <= drop_count + 16'd1;
                        end
                    end
                end
                HDR_OUT: begin
                    if (m_hdr_ready) begin
                        state       <= PASS;
                        m_hdr_valid <= 1'b0;
                    end
                end
                PASS: begin
                    if (beat_fire && s_payload_tlast) state <= IDLE;
                end
                DROP: begin
                    if (beat_fire && s_payload_tlast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_port_filter.sv
// tb/tb_udp_rx_port_filter.sv - scoreboard bench for udp_rx_port_filter
module tb_udp_rx_port_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_hdr_valid = 1'b0;
    logic        s_hdr_ready;
    logic [31:0] s_hdr_ip_source_ip = '0;
    logic [15:0] s_hdr_source_port = '0;
    logic [15:0] s_hdr_dest_port = '0;
    logic [15:0] s_hdr_length = '0;
    logic        m_hdr_valid;
    logic        m_hdr_ready = 1'b1;
    logic [31:0] m_hdr_ip_source_ip;
    logic [15:0] m_hdr_source_port;
    logic [15:0] m_hdr_length;
    logic [7:0]  s_payload_tdata = '0;
    logic        s_payload_tvalid = 1'b0;
    logic        s_payload_tready;
    logic        s_payload_tlast = 1'b0;
    logic [7:0]  m_payload_tdata;
    logic        m_payload_tvalid;
    logic        m_payload_tready = 1'b1;
    logic        m_payload_tlast;
    logic [15:0] drop_count;

    udp_rx_port_filter dut (
        .clk(clk), .rst(rst),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_hdr_ip_source_ip(s_hdr_ip_source_ip), .s_hdr_source_port(s_hdr_source_port),
        .s_hdr_dest_port(s_hdr_dest_port), .s_hdr_length(s_hdr_length),
        .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
        .m_hdr_ip_source_ip(m_hdr_ip_source_ip), .m_hdr_source_port(m_hdr_source_port),
        .m_hdr_length(m_hdr_length),
        .s_payload_tdata(s_payload_tdata), .s_payload_tvalid(s_payload_tvalid),
        .s_payload_tready(s_payload_tready), .s_payload_tlast(s_payload_tlast),
        .m_payload_tdata(m_payload_tdata), .m_payload_tvalid(m_payload_tvalid),
        .m_payload_tready(m_payload_tready), .m_payload_tlast(m_payload_tlast),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hdr_acc_cyc = 0;
    int tlast_cyc = 0;
    logic tog_en = 1'b0;

    logic [63:0] exp_hdr_q[$];
    logic [8:0]  exp_beat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (tog_en) m_payload_tready = ~m_payload_tready;
    end

    // Monitor: pops expectations whenever the DUT completes an output handshake.
    logic [63:0] prev_hdr = '0;
    logic        prev_hold = 1'b0;
    always @(negedge clk) begin
        logic [63:0] cur;
        logic [63:0] eh;
        logic [8:0]  eb;
        if (!rst) begin
            cur = {m_hdr_ip_source_ip, m_hdr_source_port, m_hdr_length};
            if (m_hdr_valid && prev_hold) chk("hdr_stable", cur, prev_hdr);
            prev_hold = m_hdr_valid && !m_hdr_ready;
            prev_hdr  = cur;
            if (m_hdr_valid && m_hdr_ready) begin
                if (exp_hdr_q.size() == 0) chk("hdr_unexpected", 64'd1, 64'd0);
                else begin
                    eh = exp_hdr_q.pop_front();
                    chk("hdr_fields", cur, eh);
                end
            end
            if (m_payload_tvalid) chk("tready_mirror", {63'd0, s_payload_tready}, {63'd0, m_payload_tready});
            if (m_payload_tvalid && m_payload_tready) begin
                if (exp_beat_q.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
                else begin
                    eb = exp_beat_q.pop_front();
                    chk("beat", {55'd0, m_payload_tlast, m_payload_tdata}, {55'd0, eb});
                end
            end
        end else prev_hold = 1'b0;
    end

    task automatic send_hdr(input logic [15:0] dp, input logic [15:0] len,
                            input logic [31:0] ip, input logic [15:0] sp);
        int t = 0;
        s_hdr_valid = 1'b1;
        s_hdr_dest_port = dp;
        s_hdr_length = len;
        s_hdr_ip_source_ip = ip;
        s_hdr_source_port = sp;
        do begin
            @(negedge clk);
            t++;
        end while (!s_hdr_ready && t < 300);
        if (t >= 300) chk("hdr_accept_timeout", 64'd1, 64'd0);
        hdr_acc_cyc = cyc;
        @(posedge clk);
        #1;
        s_hdr_valid = 1'b0;
    endtask

    task automatic send_payload(input logic [7:0] base, input int n, input int n_send);
        for (int i = 0; i < n_send; i++) begin
            int t = 0;
            s_payload_tdata = base + 8'(i);
            s_payload_tlast = (i == n - 1);
            s_payload_tvalid = 1'b1;
            do begin
                @(negedge clk);
                t++;
            end while (!s_payload_tready && t < 300);
            if (t >= 300) chk("beat_accept_timeout", 64'd1, 64'd0);
            if (s_payload_tlast) tlast_cyc = cyc;
            @(posedge clk);
            #1;
        end
        s_payload_tvalid = 1'b0;
        s_payload_tlast = 1'b0;
    endtask

    task automatic expect_dgram(input logic [15:0] len, input logic [31:0] ip, input logic [15:0] sp,
                                input logic [7:0] base, input int n);
        exp_hdr_q.push_back({ip, sp, len});
        for (int i = 0; i < n; i++) exp_beat_q.push_back({(i == n - 1), base + 8'(i)});
    endtask

    task automatic dgram(input logic [15:0] dp, input logic [15:0] len, input logic [31:0] ip,
                         input logic [15:0] sp, input logic [7:0] base, input int n, input bit pass);
        if (pass) expect_dgram(len, ip, sp, base, n);
        fork
            begin
                send_hdr(dp, len, ip, sp);
                @(negedge clk);
                chk("hdr_valid_latency", {63'd0, m_hdr_valid}, {63'd0, pass});
            end
            send_payload(base, n, n);
        join
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_hdr_ready", {63'd0, s_hdr_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", {s_hdr_ready, m_hdr_valid, m_payload_tvalid, drop_count}, {1'b1, 2'b00, 16'd0});
        chk("rst_fields", {m_hdr_ip_source_ip, m_hdr_source_port, m_hdr_length}, 64'd0);
        @(posedge clk);
        #1;

        // Matching datagram
        dgram(16'd1234, 16'd12, 32'hC0A80001, 16'd5000, 8'hA0, 4, 1'b1);
        chk("match_drop_count", {48'd0, drop_count}, 64'd0);
        // Wrong port
        dgram(16'd80, 16'd12, 32'h0A000001, 16'd6000, 8'hB0, 4, 1'b0);
        chk("mismatch_drop_count", {48'd0, drop_count}, 64'd1);
        // Length below minimum
        dgram(16'd1234, 16'd5, 32'h0A000002, 16'd6001, 8'hC0, 2, 1'b0);
        chk("short_drop_count", {48'd0, drop_count}, 64'd2);
        // Length exactly at the minimum: one tlast beat, forwarded
        dgram(16'd1234, 16'd8, 32'h0A000003, 16'd6002, 8'hD0, 1, 1'b1);
        // One below the minimum
        dgram(16'd1234, 16'd7, 32'h0A000004, 16'd6003, 8'hD8, 1, 1'b0);
        chk("len7_drop_count", {48'd0, drop_count}, 64'd3);

        // Backpressure on header then toggling payload ready
        m_hdr_ready = 1'b0;
        tog_en = 1'b1;
        expect_dgram(16'd14, 32'hDEADBEEF, 16'd7000, 8'h10, 6);
        fork
            begin
                send_hdr(16'd1234, 16'd14, 32'hDEADBEEF, 16'd7000);
                repeat (5) @(posedge clk);
                #1;
                m_hdr_ready = 1'b1;
            end
            send_payload(8'h10, 6, 6);
        join
        tog_en = 1'b0;
        m_payload_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back headers: second accepted the cycle after the first tlast
        expect_dgram(16'd11, 32'h01020304, 16'd100, 8'h20, 3);
        expect_dgram(16'd10, 32'h05060708, 16'd101, 8'h30, 2);
        fork
            begin
                send_hdr(16'd1234, 16'd11, 32'h01020304, 16'd100);
                send_hdr(16'd1234, 16'd10, 32'h05060708, 16'd101);
            end
            begin
                send_payload(8'h20, 3, 3);
                chk("b2b_first_tlast_seen", 64'(tlast_cyc > 0), 64'd1);
                begin
                    int first_tlast;
                    first_tlast = tlast_cyc;
                    send_payload(8'h30, 2, 2);
                    chk("b2b_accept_cycle", 64'(hdr_acc_cyc), 64'(first_tlast + 1));
                end
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-PASS after 2 of 4 bytes
        expect_dgram(16'd12, 32'hAABBCCDD, 16'd900, 8'h40, 2);
        exp_beat_q[$][8] = 1'b0;
        fork
            send_hdr(16'd1234, 16'd12, 32'hAABBCCDD, 16'd900);
            send_payload(8'h40, 4, 2);
        join
        rst = 1'b1;
        s_payload_tdata = 8'h42;
        s_payload_tvalid = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {s_hdr_ready, s_payload_tready, m_payload_tvalid}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_payload_tvalid = 1'b0;
        @(negedge clk);
        chk("midrst_state", {s_hdr_ready, m_hdr_valid, m_payload_tvalid, drop_count}, {1'b1, 2'b00, 16'd0});
        chk("midrst_fields", {m_hdr_ip_source_ip, m_hdr_source_port, m_hdr_length}, 64'd0);
        chk("midrst_queue", 64'(exp_beat_q.size() + exp_hdr_q.size()), 64'd0);
        @(posedge clk);
        #1;
        dgram(16'd1234, 16'd12, 32'h11223344, 16'd901, 8'h50, 4, 1'b1);
        chk("post_rst_drop_count", {48'd0, drop_count}, 64'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("final_hdr_queue", 64'(exp_hdr_q.size()), 64'd0);
        chk("final_beat_queue", 64'(exp_beat_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
